interface_hcsr04: RTL and testbench

Measurement front-end for the digital tape measure (trena). Sits directly upstream of the trena control unit. On request it fires the HC-SR04 trigger pulse, times the echo pulse, and converts its width to whole centimetres as 3 BCD digits. It signals completion with a one-cycle pronto pulse, which the control unit consumes as fim_medida; the control unit then serialises the digits. The block also flags a timeout when no valid echo arrives.

---
 rtl/interface_hcsr04_if.sv | 23 ++
 rtl/interface_hcsr04.sv | 158 +++++++++++++++
 tb/tb_interface_hcsr04.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/interface_hcsr04_if.sv
// Signal bundle between the HC-SR04 front-end and its controller.
//   medir     : measurement request (level), from the controller
//   echo      : raw sensor echo (asynchronous)
//   trigger   : sensor trigger pulse
//   medida    : 3-digit BCD distance in cm ([11:8] hundreds .. [3:0] units)
//   pronto    : one-cycle completion strobe
//   erro      : 1 = last measurement timed out
//   db_estado : current FSM state code, debug only
// slave is the front-end side, master is the controller/sensor side.
interface interface_hcsr04_if;
   logic        medir;
   logic        echo;
   logic        trigger;
   logic [11:0] medida;
   logic        pronto;
   logic        erro;
   logic [2:0]  db_estado;

   modport master (output medir, echo,
                   input  trigger, medida, pronto, erro, db_estado);
   modport slave  (input  medir, echo,
                   output trigger, medida, pronto, erro, db_estado);
endinterface

// File: rtl/interface_hcsr04.sv
// HC-SR04 measurement front-end: on request fires the trigger pulse, times
// the echo high width and converts it to whole centimetres (3 BCD digits,
// rounded to nearest), flagging a timeout when no usable echo arrives.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : interface_hcsr04_if.slave (medir, echo in; trigger, medida,
//           pronto, erro, db_estado out)
module interface_hcsr04 #(
   parameter int TRIGGER_CYCLES = 500,
   parameter int CYCLES_PER_CM  = 2941,
   parameter int ECHO_TIMEOUT   = 3000000
) (
   input  logic                 clock,
   input  logic                 reset,
   interface_hcsr04_if.slave    bus
);

   localparam int TW = $clog2(TRIGGER_CYCLES + 1);
   localparam int RW = $clog2(CYCLES_PER_CM + 1);
   localparam int OW = $clog2(ECHO_TIMEOUT + 1);

   localparam logic [TW-1:0] TRIG_LAST = TW'(TRIGGER_CYCLES - 1);
   localparam logic [RW-1:0] RES_LAST  = RW'(CYCLES_PER_CM - 1);
   localparam logic [RW-1:0] RES_HALF  = RW'(CYCLES_PER_CM / 2);
   // Waiting for the rise: last espera cycle is chosen so pronto lands
   // exactly ECHO_TIMEOUT cycles after entering espera (falha + final follow).
   localparam logic [OW-1:0] WAIT_LAST = OW'(ECHO_TIMEOUT - 2);
   localparam logic [OW-1:0] HIGH_LAST = OW'(ECHO_TIMEOUT - 1);

   typedef enum logic [2:0] {
      INICIAL       = 3'd0,
      PREPARACAO    = 3'd1,
      ENVIA_TRIGGER = 3'd2,
      ESPERA_ECHO   = 3'd3,
      MEDE          = 3'd4,
      ARREDONDA     = 3'd5,
      FALHA         = 3'd6,
      FINAL         = 3'd7
   } state_t;

   state_t        state;
   logic          echo_m, echo_s;
   logic [TW-1:0] trig_cnt;
   logic [RW-1:0] res_cnt;
   logic [OW-1:0] to_cnt;
   logic [11:0]   acc;
   logic          stuck;

   // BCD +1 with ripple carry, saturating at 999.
   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      if (v != 12'h999) begin
         if (v[3:0] != 4'd9) r[3:0] = v[3:0] + 4'd1;
         else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd9) r[7:4] = v[7:4] + 4'd1;
            else begin
               r[7:4]  = 4'd0;
               r[11:8] = v[11:8] + 4'd1;
            end
         end
      end
      return r;
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         echo_m <= 1'b0;
         echo_s <= 1'b0;
      end else begin
         echo_m <= bus.echo;
         echo_s <= echo_m;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= INICIAL;
         trig_cnt    <= '0;
         res_cnt     <= '0;
         to_cnt      <= '0;
         acc         <= 12'h000;
         stuck       <= 1'b0;
         bus.trigger <= 1'b0;
         bus.pronto  <= 1'b0;
         bus.erro    <= 1'b0;
         bus.medida  <= 12'h000;
      end else begin
         bus.pronto <= 1'b0;
         case (state)
            INICIAL: if (bus.medir) state <= PREPARACAO;
            PREPARACAO: begin
               trig_cnt    <= '0;
               res_cnt     <= '0;
               to_cnt      <= '0;
               acc         <= 12'h000;
               stuck       <= 1'b0;
               bus.trigger <= 1'b1;
               state       <= ENVIA_TRIGGER;
            end
            ENVIA_TRIGGER: begin
               if (trig_cnt == TRIG_LAST) begin
                  bus.trigger <= 1'b0;
                  state       <= ESPERA_ECHO;
               end else trig_cnt <= trig_cnt + 1'b1;
            end
            ESPERA_ECHO: begin
               if (echo_s) begin
                  // The rise cycle is the first echo-high cycle: count it.
                  if (res_cnt == RES_LAST) begin
                     res_cnt <= '0;
                     acc     <= bcd_inc(acc);
                  end else res_cnt <= res_cnt + 1'b1;
                  to_cnt <= '0;
                  state  <= MEDE;
               end else begin
                  if (to_cnt == WAIT_LAST) state <= FALHA;
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            MEDE: begin
               if (!echo_s) state <= ARREDONDA;
               else begin
                  if (res_cnt == RES_LAST) begin
                     res_cnt <= '0;
                     acc     <= bcd_inc(acc);
                  end else res_cnt <= res_cnt + 1'b1;
                  if (to_cnt == HIGH_LAST) begin
                     stuck <= 1'b1;
                     state <= FALHA;
                  end
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            ARREDONDA: begin
               bus.medida <= (res_cnt >= RES_HALF) ? bcd_inc(acc) : acc;
               bus.erro   <= 1'b0;
               bus.pronto <= 1'b1;
               state      <= FINAL;
            end
            FALHA: begin
               bus.erro <= 1'b1;
               // No echo: keep the last good reading. Stuck echo: report max.
               if (stuck) bus.medida <= 12'h999;
               bus.pronto <= 1'b1;
               state      <= FINAL;
            end
            FINAL: state <= INICIAL;
            default: state <= INICIAL;
         endcase
      end
   end

   assign bus.db_estado = state;

endmodule

// File: tb/tb_interface_hcsr04.sv
module tb_interface_hcsr04;
   localparam int TRIG = 10;
   localparam int CPC  = 8;
   localparam int TMO  = 9000;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   interface_hcsr04_if bus();

   interface_hcsr04 #(.TRIGGER_CYCLES(TRIG), .CYCLES_PER_CM(CPC), .ECHO_TIMEOUT(TMO)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #10 clock = ~clock;

   // Reference: width in cycles -> nearest whole cm, capped at 999, as BCD.
   function automatic logic [11:0] model_bcd(input int w);
      int cm;
      cm = w / CPC + (((w % CPC) >= CPC / 2) ? 1 : 0);
      if (cm > 999) cm = 999;
      return {4'(cm / 100), 4'((cm / 10) % 10), 4'(cm % 10)};
   endfunction

   // One complete measurement; returns observations, checks nothing.
   task automatic measure(input int w, input int dly, output logic [11:0] m, output logic e,
                          output int trig_n, output int lat, output int npr, output bit ok);
      int g;
      ok = 1'b1; trig_n = 0; lat = 0; npr = 0; m = 12'hxxx; e = 1'bx;
      bus.medir = 1'b1;
      g = 0;
      do begin
         @(negedge clock);
         bus.medir = 1'b0;
         if (bus.trigger === 1'b1) trig_n++;
         g++;
      end while (bus.db_estado !== 3'd3 && g < 1000);
      if (bus.db_estado !== 3'd3) begin ok = 1'b0; return; end
      repeat (dly) @(negedge clock);
      bus.echo = 1'b1;
      repeat (w) @(negedge clock);
      bus.echo = 1'b0;
      do begin
         @(negedge clock);
         lat++;
      end while (bus.pronto !== 1'b1 && lat < 200);
      if (bus.pronto !== 1'b1) begin ok = 1'b0; return; end
      m = bus.medida; e = bus.erro; npr = 1;
      repeat (5) begin
         @(negedge clock);
         if (bus.pronto === 1'b1) npr++;
      end
   endtask

   task automatic test_reset();
      int g;
      repeat (3) @(negedge clock);
      total_cnt++; if (bus.trigger !== 1'b0) $display("FAIL reset_trigger got %b want 0", bus.trigger); else pass_cnt++;
      total_cnt++; if (bus.pronto !== 1'b0) $display("FAIL reset_pronto got %b want 0", bus.pronto); else pass_cnt++;
      total_cnt++; if (bus.erro !== 1'b0) $display("FAIL reset_erro got %b want 0", bus.erro); else pass_cnt++;
      total_cnt++; if (bus.medida !== 12'h000) $display("FAIL reset_medida got %h want 000", bus.medida); else pass_cnt++;
      total_cnt++; if (bus.db_estado !== 3'd0) $display("FAIL reset_estado got %0d want 0", bus.db_estado); else pass_cnt++;
      reset = 1'b0;
      bus.medir = 1'b1;
      g = 0;
      do begin @(negedge clock); g++; end while (bus.db_estado !== 3'd2 && g < 100);
      bus.medir = 1'b0;
      total_cnt++; if (bus.trigger !== 1'b1) $display("FAIL reset_pre_trigger got %b want 1", bus.trigger); else pass_cnt++;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      #1;
      total_cnt++; if (bus.trigger !== 1'b0) $display("FAIL reset_async_trigger got %b want 0", bus.trigger); else pass_cnt++;
      total_cnt++; if (bus.db_estado !== 3'd0) $display("FAIL reset_async_estado got %0d want 0", bus.db_estado); else pass_cnt++;
      @(negedge clock);
      reset = 1'b0;
      g = 0;
      repeat (20) begin @(negedge clock); if (bus.pronto === 1'b1) g++; end
      total_cnt++; if (g !== 0) $display("FAIL reset_no_pronto got %0d pulses want 0", g); else pass_cnt++;
      total_cnt++; if (bus.medida !== 12'h000 || bus.erro !== 1'b0) $display("FAIL reset_outputs got %h/%b want 000/0", bus.medida, bus.erro); else pass_cnt++;
   endtask

   task automatic test_basic();
      logic [11:0] m; logic e; int tn, lat, npr; bit ok;
      measure(20 * CPC, 3, m, e, tn, lat, npr, ok);
      total_cnt++; if (ok !== 1'b1) $display("FAIL basic_timeout got no pronto want pronto"); else pass_cnt++;
      total_cnt++; if (tn !== TRIG) $display("FAIL basic_trigger_len got %0d want %0d", tn, TRIG); else pass_cnt++;
      total_cnt++; if (m !== 12'h020) $display("FAIL basic_medida got %h want 020", m); else pass_cnt++;
      total_cnt++; if (e !== 1'b0) $display("FAIL basic_erro got %b want 0", e); else pass_cnt++;
      total_cnt++; if (lat !== 4) $display("FAIL basic_latency got %0d want 4", lat); else pass_cnt++;
      total_cnt++; if (npr !== 1) $display("FAIL basic_pronto_count got %0d want 1", npr); else pass_cnt++;
   endtask

   task automatic test_timeout();
      int g, k;
      bus.medir = 1'b1;
      g = 0;
      do begin @(negedge clock); g++; end while (bus.trigger !== 1'b1 && g < 100);
      bus.medir = 1'b0;
      // Short echo entirely inside the trigger pulse must be ignored.
      bus.echo = 1'b1;
      repeat (3) @(negedge clock);
      bus.echo = 1'b0;
      g = 0;
      while (bus.db_estado !== 3'd3 && g < 100) begin @(negedge clock); g++; end
      k = 0;
      do begin @(negedge clock); k++; end while (bus.pronto !== 1'b1 && k < TMO + 100);
      total_cnt++; if (k !== TMO) $display("FAIL timeout_delay got %0d want %0d", k, TMO); else pass_cnt++;
      total_cnt++; if (bus.erro !== 1'b1) $display("FAIL timeout_erro got %b want 1", bus.erro); else pass_cnt++;
      total_cnt++; if (bus.medida !== 12'h020) $display("FAIL timeout_medida got %h want 020", bus.medida); else pass_cnt++;
      @(negedge clock);
      total_cnt++; if (bus.pronto !== 1'b0) $display("FAIL timeout_pronto_width got %b want 0", bus.pronto); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int widths [3] = '{7 * CPC + 1, 3 * CPC + 5, 12 * CPC};
      logic [11:0] exp_m [3] = '{12'h007, 12'h004, 12'h012};
      int g, tn;
      bus.medir = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tn = 0; g = 0;
         do begin
            @(negedge clock);
            if (bus.trigger === 1'b1) tn++;
            g++;
         end while (bus.db_estado !== 3'd3 && g < 1000);
         repeat (2) @(negedge clock);
         bus.echo = 1'b1;
         repeat (widths[i]) @(negedge clock);
         bus.echo = 1'b0;
         g = 0;
         do begin @(negedge clock); g++; end while (bus.pronto !== 1'b1 && g < 200);
         total_cnt++; if (tn !== TRIG) $display("FAIL b2b_trigger_len[%0d] got %0d want %0d", i, tn, TRIG); else pass_cnt++;
         total_cnt++; if (bus.medida !== exp_m[i]) $display("FAIL b2b_medida[%0d] got %h want %h", i, bus.medida, exp_m[i]); else pass_cnt++;
         total_cnt++; if (bus.erro !== 1'b0) $display("FAIL b2b_erro[%0d] got %b want 0", i, bus.erro); else pass_cnt++;
         @(negedge clock);
         total_cnt++; if (bus.pronto !== 1'b0 || bus.db_estado !== 3'd0) $display("FAIL b2b_after_final[%0d] got pronto=%b estado=%0d want 0/0", i, bus.pronto, bus.db_estado); else pass_cnt++;
      end
      bus.medir = 1'b0;
      repeat (3) @(negedge clock);
      total_cnt++; if (bus.db_estado !== 3'd0) $display("FAIL b2b_idle got %0d want 0", bus.db_estado); else pass_cnt++;
   endtask

   task automatic test_rounding();
      int widths [5] = '{5 * CPC + CPC / 2 - 1, 5 * CPC + CPC / 2, 99 * CPC + CPC - 1, CPC / 2 - 1, CPC / 2};
      logic [11:0] exp_m [5] = '{12'h005, 12'h006, 12'h100, 12'h000, 12'h001};
      logic [11:0] m; logic e; int tn, lat, npr; bit ok;
      for (int i = 0; i < 5; i++) begin
         measure(widths[i], i, m, e, tn, lat, npr, ok);
         total_cnt++; if (m !== exp_m[i]) $display("FAIL round_medida[%0d] got %h want %h", i, m, exp_m[i]); else pass_cnt++;
         total_cnt++; if (e !== 1'b0 || npr !== 1) $display("FAIL round_status[%0d] got erro=%b pulses=%0d want 0/1", i, e, npr); else pass_cnt++;
      end
   endtask

   task automatic test_saturation();
      int widths [3] = '{998 * CPC + CPC / 2, 999 * CPC + CPC / 2 + 1, 1005 * CPC};
      logic [11:0] m; logic e; int tn, lat, npr; bit ok;
      for (int i = 0; i < 3; i++) begin
         measure(widths[i], 1, m, e, tn, lat, npr, ok);
         total_cnt++; if (m !== 12'h999 || e !== 1'b0) $display("FAIL sat_medida[%0d] got %h/%b want 999/0", i, m, e); else pass_cnt++;
      end
   endtask

   task automatic test_random();
      logic [11:0] m, exp; logic e; int w, d, tn, lat, npr; bit ok;
      for (int i = 0; i < 6; i++) begin
         w = int'($urandom_range(1, 130 * CPC));
         d = int'($urandom_range(0, 12));
         exp = model_bcd(w);
         measure(w, d, m, e, tn, lat, npr, ok);
         total_cnt++; if (m !== exp) $display("FAIL rand_medida[%0d] w=%0d got %h want %h", i, w, m, exp); else pass_cnt++;
         total_cnt++; if (lat !== 4 || tn !== TRIG) $display("FAIL rand_timing[%0d] got lat=%0d trig=%0d want 4/%0d", i, lat, tn, TRIG); else pass_cnt++;
      end
   endtask

   task automatic test_stuck();
      int g, k, npr;
      bus.medir = 1'b1;
      g = 0;
      do begin @(negedge clock); bus.medir = 1'b0; g++; end while (bus.db_estado !== 3'd3 && g < 1000);
      bus.echo = 1'b1;
      k = 0;
      do begin @(negedge clock); k++; end while (bus.pronto !== 1'b1 && k < 2 * TMO);
      total_cnt++; if (k < TMO + 2 || k > TMO + 6) $display("FAIL stuck_delay got %0d want %0d..%0d", k, TMO + 2, TMO + 6); else pass_cnt++;
      total_cnt++; if (bus.medida !== 12'h999 || bus.erro !== 1'b1) $display("FAIL stuck_result got %h/%b want 999/1", bus.medida, bus.erro); else pass_cnt++;
      npr = 0;
      repeat (8) begin @(negedge clock); if (bus.pronto === 1'b1) npr++; end
      total_cnt++; if (npr !== 0) $display("FAIL stuck_extra_pronto got %0d want 0", npr); else pass_cnt++;
      bus.echo = 1'b0;
   endtask

   initial begin
      bus.medir = 1'b0;
      bus.echo  = 1'b0;
      test_reset();
      test_basic();
      test_timeout();
      test_back_to_back();
      test_rounding();
      test_saturation();
      test_random();
      test_stuck();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
